// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types, funct3 codes and helpers for the load/store unit.
//   lsu_state_e       : controller state encoding (IDLE, MEM, WB)
//   F3_*              : RV32I width/sign codes used by loads and stores
//   lsu_legal()       : legality/alignment check for one request
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    WB   = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unsigned variants only exist for loads; stores accept B/H/W only.
  function automatic logic lsu_legal(input logic we, input logic [2:0] f3,
                                     input logic [1:0] lo);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~lo[0];
      F3_W:    ok = (lo == 2'b00);
      F3_BU:   ok = ~we;
      F3_HU:   ok = ~we & ~lo[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: selects the addressed byte/halfword lane of a load word
// and sign- or zero-extends it according to funct3.
//   rdata_i   [31:0] : word returned by memory
//   addr_lo_i [1:0]  : byte offset of the access
//   funct3_i  [2:0]  : load width/sign code
//   data_o    [31:0] : extended result for the register file
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  // Shift the addressed lane down to bit 0; halfwords are already aligned.
  assign shifted = rdata_i >> {addr_lo_i, 3'b000};

  always_comb begin
    data_o = rdata_i;
    case (funct3_i)
      F3_B:    data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   data_o = {24'h0, shifted[7:0]};
      F3_H:    data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   data_o = {16'h0, shifted[15:0]};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: executes one load or store per accepted request against a
// word-addressed data memory and writes load results to the register file.
//   req_*   : request handshake from execute (valid/ready, we, funct3, addr,
//             wdata, rd)
//   mem_*   : data memory handshake (valid/ready, we, addr, wstrb, wdata, rdata)
//   wb_*    : register file write port (we, wa, wd)
//   done, err_align, err_timeout : one-cycle status pulses
// All outputs are registers; nothing on req_* reaches mem_* combinationally.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        wb_we,
  output logic [4:0]  wb_wa,
  output logic [31:0] wb_wd,
  output logic        done,
  output logic        err_align,
  output logic        err_timeout
);

  localparam bit              TO_EN   = (TIMEOUT_CYCLES != 0);
  // Timeout fires on the MEM cycle whose increment would reach the limit.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

  lsu_state_e  state_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  lo_q;
  logic [4:0]  rd_q;
  logic [TO_W-1:0] count_q;

  logic        req_ready_q, mem_valid_q, mem_we_q, wb_we_q;
  logic        done_q, err_align_q, err_timeout_q;
  logic [31:0] mem_addr_q, mem_wdata_q, wb_wd_q;
  logic [3:0]  mem_wstrb_q;
  logic [4:0]  wb_wa_q;

  logic [3:0]  strb_d;
  logic [31:0] wdata_d;
  logic [31:0] load_data;
  logic        timeout_hit;

  lsu_load_align u_align (
    .rdata_i   (mem_rdata),
    .addr_lo_i (lo_q),
    .funct3_i  (f3_q),
    .data_o    (load_data)
  );

  always_comb begin
    strb_d  = 4'b0000;
    wdata_d = 32'h0;
    if (req_we) begin
      case (req_funct3)
        F3_B: begin
          strb_d  = 4'b0001 << req_addr[1:0];
          wdata_d = {4{req_wdata[7:0]}};
        end
        F3_H: begin
          strb_d  = 4'b0011 << req_addr[1:0];
          wdata_d = {2{req_wdata[15:0]}};
        end
        default: begin
          strb_d  = 4'b1111;
          wdata_d = req_wdata;
        end
      endcase
    end
  end

  assign timeout_hit = TO_EN && (count_q == TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      we_q          <= 1'b0;
      f3_q          <= 3'b000;
      lo_q          <= 2'b00;
      rd_q          <= 5'd0;
      count_q       <= '0;
      req_ready_q   <= 1'b1;
      mem_valid_q   <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= 32'h0;
      mem_wstrb_q   <= 4'b0000;
      mem_wdata_q   <= 32'h0;
      wb_we_q       <= 1'b0;
      wb_wa_q       <= 5'd0;
      wb_wd_q       <= 32'h0;
      done_q        <= 1'b0;
      err_align_q   <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      done_q        <= 1'b0;
      err_align_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      wb_we_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q <= req_we;
            f3_q <= req_funct3;
            lo_q <= req_addr[1:0];
            rd_q <= req_rd;
            if (lsu_legal(req_we, req_funct3, req_addr[1:0])) begin
              state_q     <= MEM;
              req_ready_q <= 1'b0;
              mem_valid_q <= 1'b1;
              mem_we_q    <= req_we;
              mem_addr_q  <= {req_addr[31:2], 2'b00};
              mem_wstrb_q <= strb_d;
              mem_wdata_q <= wdata_d;
              count_q     <= '0;
            end else begin
              err_align_q <= 1'b1;
            end
          end
        end
        MEM: begin
          // Completion is checked first so it wins over a same-cycle timeout.
          if (mem_ready) begin
            mem_valid_q <= 1'b0;
            count_q     <= '0;
            done_q      <= we_q;
            if (we_q) begin
              state_q     <= IDLE;
              req_ready_q <= 1'b1;
            end else begin
              state_q <= WB;
              wb_wa_q <= rd_q;
              wb_wd_q <= load_data;
              wb_we_q <= (rd_q != 5'd0);
              done_q  <= 1'b1;
            end
          end else if (timeout_hit) begin
            mem_valid_q   <= 1'b0;
            count_q       <= '0;
            state_q       <= IDLE;
            req_ready_q   <= 1'b1;
            err_timeout_q <= 1'b1;
          end else begin
            count_q <= count_q + 1'b1;
          end
        end
        WB: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          mem_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign mem_valid   = mem_valid_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wstrb   = mem_wstrb_q;
  assign mem_wdata   = mem_wdata_q;
  assign wb_we       = wb_we_q;
  assign wb_wa       = wb_wa_q;
  assign wb_wd       = wb_wd_q;
  assign done        = done_q;
  assign err_align   = err_align_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vectors with hand-computed expectations for
// load_store_unit, built with a 4-cycle memory timeout.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        mem_valid, mem_ready, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        wb_we;
  logic [4:0]  wb_wa;
  logic [31:0] wb_wd;
  logic        done, err_align, err_timeout;

  int n_checks = 0;
  int n_pass   = 0;

  load_store_unit #(.TIMEOUT_CYCLES(4), .TO_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
    .done(done), .err_align(err_align), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [4:0] rd);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    req_rd     = rd;
    tick();
    req_valid  = 1'b0;
  endtask

  // Single-cycle load: completes on the first MEM cycle, checks the writeback.
  task automatic load1(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [4:0] rd, input logic [31:0] rdata, input logic [31:0] exp);
    send(1'b0, f3, addr, 32'h0, rd);
    mem_ready = 1'b1;
    mem_rdata = rdata;
    tick();
    mem_ready = 1'b0;
    chk({tag, "_wb_we"}, wb_we, 1);
    chk({tag, "_wb_wa"}, wb_wa, rd);
    chk({tag, "_wb_wd"}, wb_wd, exp);
    tick();
  endtask

  task automatic store1(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb, input logic [31:0] data);
    send(1'b1, f3, addr, wdata, 5'd0);
    chk({tag, "_mem_valid"}, mem_valid, 1);
    chk({tag, "_mem_we"}, mem_we, 1);
    chk({tag, "_mem_addr"}, mem_addr, {addr[31:2], 2'b00});
    chk({tag, "_wstrb"}, mem_wstrb, strb);
    chk({tag, "_wdata"}, mem_wdata, data);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk({tag, "_done"}, done, 1);
    chk({tag, "_wb_we"}, wb_we, 0);
    chk({tag, "_ready_after"}, req_ready, 1);
    tick();
    chk({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
    mem_ready = 1'b0; mem_rdata = 32'h0;
    tick();
    tick();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_wstrb", mem_wstrb, 4'h0);
    chk("rst_wb_we", wb_we, 0);
    chk("rst_wb_wd", wb_wd, 32'h0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    tick();

    store1("sw", F3_W, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
    store1("sb", F3_B, 32'h0000_0101, 32'h0000_00AB, 4'b0010, 32'hABAB_ABAB);
    store1("sh", F3_H, 32'h0000_0102, 32'h1234_CDEF, 4'b1100, 32'hCDEF_CDEF);

    load1("lb", F3_B, 32'h0000_0203, 5'd5, 32'h80FF_1234, 32'hFFFF_FF80);
    chk("lb_wd_hold", wb_wd, 32'hFFFF_FF80);
    chk("lb_we_clear", wb_we, 0);
    load1("lbu", F3_BU, 32'h0000_0203, 5'd5, 32'h80FF_1234, 32'h0000_0080);
    load1("lhu", F3_HU, 32'h0000_0200, 5'd9, 32'h1234_8001, 32'h0000_8001);
    load1("lw", F3_W, 32'h0000_0204, 5'd31, 32'hCAFE_F00D, 32'hCAFE_F00D);

    // Halfword load at offset 2 with three stall cycles.
    send(1'b0, F3_H, 32'h0000_0402, 32'h0, 5'd3);
    for (int i = 0; i < 4; i++) begin
      chk("lh_mem_valid", mem_valid, 1);
      chk("lh_mem_addr", mem_addr, 32'h0000_0400);
      chk("lh_wstrb", mem_wstrb, 4'b0000);
      chk("lh_mem_we", mem_we, 0);
      if (i == 3) begin
        mem_ready = 1'b1;
        mem_rdata = 32'h7FFF_0000;
      end
      tick();
    end
    mem_ready = 1'b0;
    chk("lh_wb_we", wb_we, 1);
    chk("lh_wb_wd", wb_wd, 32'h0000_7FFF);
    chk("lh_done", done, 1);
    chk("lh_no_timeout", err_timeout, 0);
    tick();

    // Misaligned word load and illegal store width.
    send(1'b0, F3_W, 32'h0000_0101, 32'h0, 5'd1);
    chk("mis_err_align", err_align, 1);
    chk("mis_mem_valid", mem_valid, 0);
    chk("mis_req_ready", req_ready, 1);
    tick();
    chk("mis_err_pulse", err_align, 0);
    chk("mis_mem_valid2", mem_valid, 0);
    send(1'b1, F3_BU, 32'h0000_0100, 32'h0, 5'd0);
    chk("ill_err_align", err_align, 1);
    chk("ill_mem_valid", mem_valid, 0);
    tick();

    // Timeout: count MEM cycles with no mem_ready.
    send(1'b0, F3_W, 32'h0000_0300, 32'h0, 5'd7);
    n = 0;
    while (mem_valid && n < 10) begin
      n++;
      tick();
    end
    chk("to_valid_cycles", n, 4);
    chk("to_err_timeout", err_timeout, 1);
    chk("to_wb_we", wb_we, 0);
    chk("to_req_ready", req_ready, 1);
    // Back-to-back request to rd=0 in the error-pulse cycle.
    send(1'b0, F3_W, 32'h0000_0500, 32'h0, 5'd0);
    chk("b2b_mem_valid", mem_valid, 1);
    mem_ready = 1'b1;
    mem_rdata = 32'h1234_5678;
    tick();
    mem_ready = 1'b0;
    chk("rd0_done", done, 1);
    chk("rd0_wb_we", wb_we, 0);
    tick();

    // mem_ready on the cycle the limit would be reached: completion wins.
    send(1'b0, F3_W, 32'h0000_0600, 32'h0, 5'd4);
    tick(); tick(); tick();
    chk("race_mem_valid", mem_valid, 1);
    mem_ready = 1'b1;
    mem_rdata = 32'h0BAD_F00D;
    tick();
    mem_ready = 1'b0;
    chk("race_wb_we", wb_we, 1);
    chk("race_wb_wd", wb_wd, 32'h0BAD_F00D);
    chk("race_no_timeout", err_timeout, 0);
    tick();

    // Reset asserted in the middle of MEM.
    send(1'b1, F3_W, 32'h0000_0700, 32'h1111_2222, 5'd0);
    chk("rstm_mem_valid_pre", mem_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("rstm_mem_valid", mem_valid, 0);
    chk("rstm_req_ready", req_ready, 1);
    tick();
    rst = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rstm_no_done", done, 0);
      chk("rstm_no_wb_we", wb_we, 0);
      chk("rstm_no_valid", mem_valid, 0);
    end
    mem_ready = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
